bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Two-master, one-slave arbiter in front of the system bus, the same bus the cpu data path and VirtualBus use.
- Master 0 is the CPU data port and master 1 is the CPU instruction-fetch port (later a DMA/serial engine).
- Serialises transactions onto the single slave port using fixed priority with anti-starvation.
- Aborts transactions the slave never completes, returning an error response to the issuing master.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, read/write data width.
- TIMEOUT_CYCLES, 16, ACTIVE cycles without Hready before abort; legal range >= 2.
- MAX_CONSEC, 4, maximum back-to-back grants to master 0 while master 1 waits; legal range >= 1.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- m0_req, m1_req  in  1 each  transaction request; held high with fields stable until that master's ready pulse.
- m0_address, m1_address  in  ADDR_WIDTH each  transaction address.
- m0_write, m1_write  in  1 each  1 = write, 0 = read.
- m0_size, m1_size  in  1 each  1 = word, 0 = byte.
- m0_writedata, m1_writedata  in  DATA_WIDTH each  write data.
- m0_readdata, m1_readdata  out  DATA_WIDTH each  registered read data; valid only during that master's ready pulse.
- m0_ready, m1_ready  out  1 each  one-cycle completion pulse.
- m0_response, m1_response  out  1 each  1 = error (slave error or timeout); valid with ready.
- Hrequest  out  1  slave transaction strobe.
- Haddress  out  ADDR_WIDTH  slave address.
- Hwrite  out  1  slave write enable.
- Hsize  out  1  slave size.
- Hwritedata  out  DATA_WIDTH  slave write data.
- Hreaddata  in  DATA_WIDTH  slave read data.
- Hready  in  1  slave completion.
- Hresponse  in  1  slave error; sampled with Hready.

Behaviour:
- Reset state: IDLE; every output 0; grant = 0; streak counter = 0; timeout counter = 0. Reset mid-transaction abandons it immediately with no ready pulse.
- FSM IDLE:
  - no request: stay in IDLE.
  - any request: register winner and its fields, go ACTIVE.
  - winner is master 0 if m0_req, else master 1.
  - exception: m1_req=1 and streak == MAX_CONSEC, then master 1 wins.
- FSM ACTIVE:
  - Hrequest=1; Haddress/Hwrite/Hsize/Hwritedata come from the registered fields, stable for the whole state.
  - Hready=1: capture Hreaddata (reads only; writes capture 0) and Hresponse; go DONE.
  - else, when the timeout counter reaches TIMEOUT_CYCLES-1: capture data 0 and response 1; go DONE. Hready in that same cycle takes precedence over the timeout.
- FSM DONE:
  - Hrequest=0; granted master's ready=1 with captured data/response for exactly one cycle; go IDLE.
  - Requests are ignored in DONE, so a master holding req high starts its next transaction in the following IDLE.
- Minimum latency is 3 cycles from request sampled in IDLE to the ready pulse (slave Hready in the first ACTIVE cycle).
- Slave side: Hrequest is never high outside ACTIVE. Hready/Hresponse outside ACTIVE are ignored.
- Streak counter (saturating, range 0..MAX_CONSEC), updated at the IDLE grant decision:
  - master 0 granted while m1_req=1: increment.
  - master 1 granted, or m1_req=0: clear.
- Timeout counter: cleared on IDLE->ACTIVE; increments each ACTIVE cycle.
- Ungranted master outputs: ready=0, response=0; readdata holds its last value.
- Fields of the non-granted master may change freely at any time.

Decomposition:
- Shared package bus_pkg:
  - state encoding localparams: IDLE, ACTIVE, DONE.
  - size encodings: SIZE_BYTE=0, SIZE_WORD=1.
  - response encodings: RESP_OK=0, RESP_ERR=1.
- Sub-module bus_arb_priority: combinational winner selection plus streak-counter update (inputs m0_req, m1_req, streak; outputs winner, next streak).
- The FSM, timeout counter and datapath registers remain in bus_arbiter.

Test Plan:
- Single read, slave Hready in the first ACTIVE cycle with Hreaddata=0xDEADBEEF -> m0_ready pulses in the third cycle after m0_req with m0_readdata=0xDEADBEEF and response 0.
- m0 and m1 request in the same IDLE cycle, each slave access takes 2 cycles -> m0 served first, m1 starts in the next IDLE; Haddress stable throughout each ACTIVE.
- m0_req held continuously with MAX_CONSEC=4 and m1_req high -> grant order m0,m0,m0,m0,m1,m0...; streak returns to 0 after the m1 grant.
- Slave never asserts Hready, TIMEOUT_CYCLES=16 -> after 16 ACTIVE cycles the granted master gets ready=1, response=1, readdata=0; Hrequest drops.
- Hready=1 with Hresponse=1 on the cycle the timeout would fire -> slave result reported (response 1, Hreaddata captured); no double completion.
- reset asserted during ACTIVE -> Hrequest and all ready outputs 0 asynchronously; after reset release a pending m1_req is granted normally.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the two-master system bus arbiter.
//   state_t    : arbiter FSM states (IDLE, ACTIVE, DONE)
//   SIZE_*     : Hsize / mX_size encodings
//   RESP_*     : Hresponse / mX_response encodings
//   MASTER*    : grant encodings
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;

    localparam logic RESP_OK  = 1'b0;
    localparam logic RESP_ERR = 1'b1;

    localparam logic MASTER0 = 1'b0;
    localparam logic MASTER1 = 1'b1;

endpackage

// File: rtl/bus_arb_priority.sv
// Winner selection for the bus arbiter: fixed priority to master 0, with
// master 1 forced through once master 0 has taken MAX_CONSEC consecutive
// grants while master 1 was waiting.
// Ports:
//   m0_req, m1_req : current requests
//   streak         : consecutive master-0 grants taken while m1 waited
//   winner         : master that gets the bus (only meaningful if a req is up)
//   streak_next    : streak value to register when this grant is taken
module bus_arb_priority
    import bus_pkg::*;
#(
    parameter int MAX_CONSEC = 4,
    parameter int STREAK_W   = 3
) (
    input  logic                m0_req,
    input  logic                m1_req,
    input  logic [STREAK_W-1:0] streak,
    output logic                winner,
    output logic [STREAK_W-1:0] streak_next
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_CONSEC);

    always_comb begin
        winner      = MASTER0;
        streak_next = '0;

        if (m1_req && (streak >= STREAK_MAX)) begin
            winner = MASTER1;
        end else if (m0_req) begin
            winner = MASTER0;
        end else begin
            winner = MASTER1;
        end

        // The streak only grows while master 1 is actually being held off.
        if ((winner == MASTER0) && m1_req) begin
            streak_next = (streak >= STREAK_MAX) ? STREAK_MAX : streak + 1'b1;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master, one-slave system bus arbiter. Serialises master transactions
// onto the slave port (IDLE -> ACTIVE -> DONE) and aborts a transfer with an
// error response if the slave does not complete within TIMEOUT_CYCLES.
// Ports:
//   clock, reset               : clock, asynchronous active-high reset
//   mX_req/address/write/size/writedata : master X request side
//   mX_readdata/ready/response : master X completion (one-cycle ready pulse)
//   Hrequest/Haddress/Hwrite/Hsize/Hwritedata : slave request side
//   Hreaddata/Hready/Hresponse : slave completion side
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int MAX_CONSEC     = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  m0_req,
    input  logic [ADDR_WIDTH-1:0] m0_address,
    input  logic                  m0_write,
    input  logic                  m0_size,
    input  logic [DATA_WIDTH-1:0] m0_writedata,
    output logic [DATA_WIDTH-1:0] m0_readdata,
    output logic                  m0_ready,
    output logic                  m0_response,
    input  logic                  m1_req,
    input  logic [ADDR_WIDTH-1:0] m1_address,
    input  logic                  m1_write,
    input  logic                  m1_size,
    input  logic [DATA_WIDTH-1:0] m1_writedata,
    output logic [DATA_WIDTH-1:0] m1_readdata,
    output logic                  m1_ready,
    output logic                  m1_response,
    output logic                  Hrequest,
    output logic [ADDR_WIDTH-1:0] Haddress,
    output logic                  Hwrite,
    output logic                  Hsize,
    output logic [DATA_WIDTH-1:0] Hwritedata,
    input  logic [DATA_WIDTH-1:0] Hreaddata,
    input  logic                  Hready,
    input  logic                  Hresponse
);

    localparam int STREAK_W = (MAX_CONSEC < 1) ? 1 : $clog2(MAX_CONSEC + 1);
    localparam int TIMER_W  = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    state_t                  state_reg, state_next;
    logic                    grant_reg;
    logic [STREAK_W-1:0]     streak_reg;
    logic [TIMER_W-1:0]      timer_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic                    write_reg;
    logic                    size_reg;
    logic [DATA_WIDTH-1:0]   wdata_reg;

    logic                    winner;
    logic [STREAK_W-1:0]     streak_next;
    logic                    grant_en;
    logic                    finish;
    logic [DATA_WIDTH-1:0]   finish_data;
    logic                    finish_resp;

    bus_arb_priority #(
        .MAX_CONSEC (MAX_CONSEC),
        .STREAK_W   (STREAK_W)
    ) u_priority (
        .m0_req      (m0_req),
        .m1_req      (m1_req),
        .streak      (streak_reg),
        .winner      (winner),
        .streak_next (streak_next)
    );

    assign Haddress   = addr_reg;
    assign Hwrite     = write_reg;
    assign Hsize      = size_reg;
    assign Hwritedata = wdata_reg;

    always_comb begin
        state_next  = state_reg;
        grant_en    = 1'b0;
        finish      = 1'b0;
        finish_data = '0;
        finish_resp = RESP_OK;
        Hrequest    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (m0_req || m1_req) begin
                    grant_en   = 1'b1;
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                Hrequest = 1'b1;
                // A slave completion in the final timeout cycle still wins.
                if (Hready) begin
                    finish      = 1'b1;
                    finish_data = write_reg ? '0 : Hreaddata;
                    finish_resp = Hresponse;
                    state_next  = DONE;
                end else if (timer_reg == TIMER_LAST) begin
                    finish      = 1'b1;
                    finish_resp = RESP_ERR;
                    state_next  = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            grant_reg   <= MASTER0;
            streak_reg  <= '0;
            timer_reg   <= '0;
            addr_reg    <= '0;
            write_reg   <= 1'b0;
            size_reg    <= SIZE_BYTE;
            wdata_reg   <= '0;
            m0_readdata <= '0;
            m1_readdata <= '0;
            m0_ready    <= 1'b0;
            m1_ready    <= 1'b0;
            m0_response <= RESP_OK;
            m1_response <= RESP_OK;
        end else begin
            state_reg   <= state_next;
            // ready/response are pulses that live only in DONE
            m0_ready    <= 1'b0;
            m1_ready    <= 1'b0;
            m0_response <= RESP_OK;
            m1_response <= RESP_OK;

            if (grant_en) begin
                grant_reg  <= winner;
                streak_reg <= streak_next;
                timer_reg  <= '0;
                addr_reg   <= (winner == MASTER1) ? m1_address   : m0_address;
                write_reg  <= (winner == MASTER1) ? m1_write     : m0_write;
                size_reg   <= (winner == MASTER1) ? m1_size      : m0_size;
                wdata_reg  <= (winner == MASTER1) ? m1_writedata : m0_writedata;
            end else if (state_reg == ACTIVE) begin
                timer_reg <= timer_reg + 1'b1;
            end

            // Readdata is written straight into the owner's register so the
            // other master's last value is left untouched.
            if (finish) begin
                if (grant_reg == MASTER1) begin
                    m1_ready    <= 1'b1;
                    m1_response <= finish_resp;
                    m1_readdata <= finish_data;
                end else begin
                    m0_ready    <= 1'b1;
                    m0_response <= finish_resp;
                    m0_readdata <= finish_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios followed by random
// transactions, all predicted by a transaction-level reference model.
module tb_bus_arbiter;

    localparam int TIMEOUT = 16;
    localparam int MAXC    = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic [31:0] m0_address = '0, m1_address = '0;
    logic        m0_write = 1'b0, m1_write = 1'b0;
    logic        m0_size = 1'b0, m1_size = 1'b0;
    logic [31:0] m0_writedata = '0, m1_writedata = '0;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_ready, m1_ready, m0_response, m1_response;
    logic        Hrequest, Hwrite, Hsize;
    logic [31:0] Haddress, Hwritedata;
    logic [31:0] Hreaddata = '0;
    logic        Hready = 1'b0, Hresponse = 1'b0;

    int checks   = 0;
    int failures = 0;

    // reference model state
    int          streak_m = 0;
    logic [31:0] rd_model [2];
    logic [31:0] f_addr   [2];
    logic [31:0] f_wdata  [2];
    logic        f_write  [2];
    logic        f_size   [2];
    logic        obs_winner;

    bus_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(TIMEOUT), .MAX_CONSEC(MAXC)
    ) dut (
        .clock(clock), .reset(reset),
        .m0_req(m0_req), .m0_address(m0_address), .m0_write(m0_write),
        .m0_size(m0_size), .m0_writedata(m0_writedata),
        .m0_readdata(m0_readdata), .m0_ready(m0_ready), .m0_response(m0_response),
        .m1_req(m1_req), .m1_address(m1_address), .m1_write(m1_write),
        .m1_size(m1_size), .m1_writedata(m1_writedata),
        .m1_readdata(m1_readdata), .m1_ready(m1_ready), .m1_response(m1_response),
        .Hrequest(Hrequest), .Haddress(Haddress), .Hwrite(Hwrite), .Hsize(Hsize),
        .Hwritedata(Hwritedata), .Hreaddata(Hreaddata), .Hready(Hready),
        .Hresponse(Hresponse)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Fresh request fields for master m, driven onto its ports.
    task automatic new_fields(input int m, input logic wr);
        f_addr[m]  = $urandom;
        f_wdata[m] = $urandom;
        f_write[m] = wr;
        f_size[m]  = 1'($urandom_range(0, 1));
        if (m == 0) begin
            m0_address = f_addr[0]; m0_writedata = f_wdata[0];
            m0_write = f_write[0];  m0_size = f_size[0];
        end else begin
            m1_address = f_addr[1]; m1_writedata = f_wdata[1];
            m1_write = f_write[1];  m1_size = f_size[1];
        end
    endtask

    function automatic int model_winner(input logic r0, input logic r1);
        if (r1 && streak_m == MAXC) return 1;
        if (r0) return 0;
        return 1;
    endfunction

    // One full transaction starting in IDLE with requests already set.
    // The slave completes in its delay-th ACTIVE cycle (never if > TIMEOUT).
    task automatic serve(input int delay, input logic hresp, input logic [31:0] sdata);
        int          exp_m, other, exp_active, active_n, steps;
        bit          seen, fields_ok;
        logic [31:0] exp_rd;
        logic        exp_resp;

        exp_m = model_winner(m0_req, m1_req);
        if (exp_m == 0 && m1_req) streak_m = (streak_m < MAXC) ? streak_m + 1 : MAXC;
        else                      streak_m = 0;
        other = 1 - exp_m;

        if (delay <= TIMEOUT) begin
            exp_active = delay;
            exp_resp   = hresp;
            exp_rd     = f_write[exp_m] ? 32'h0 : sdata;
        end else begin
            exp_active = TIMEOUT;
            exp_resp   = 1'b1;
            exp_rd     = 32'h0;
        end

        active_n = 0; steps = 0; seen = 0; fields_ok = 1;
        for (int cyc = 0; cyc < 64 && !seen; cyc++) begin
            step();
            steps++;
            if (m0_ready || m1_ready) begin
                seen = 1;
            end else if (Hrequest) begin
                active_n++;
                if ({Haddress, Hwrite, Hsize, Hwritedata} !==
                    {f_addr[exp_m], f_write[exp_m], f_size[exp_m], f_wdata[exp_m]})
                    fields_ok = 0;
                Hready    = (active_n == delay);
                Hresponse = hresp;
                Hreaddata = (active_n == delay) ? sdata : $urandom;
            end else begin
                // outside ACTIVE the slave lines must be ignored
                Hready    = 1'($urandom_range(0, 1));
                Hresponse = 1'($urandom_range(0, 1));
                Hreaddata = $urandom;
            end
        end

        check("ready_seen", 64'(seen), 64'd1);
        obs_winner = m1_ready;
        check("ready_onehot", {62'd0, m1_ready, m0_ready}, (exp_m == 1) ? 64'd2 : 64'd1);
        check("response", (exp_m == 1) ? 64'(m1_response) : 64'(m0_response), 64'(exp_resp));
        check("other_response", (exp_m == 1) ? 64'(m0_response) : 64'(m1_response), 64'd0);
        check("readdata", (exp_m == 1) ? 64'(m1_readdata) : 64'(m0_readdata), 64'(exp_rd));
        check("other_readdata_hold", (exp_m == 1) ? 64'(m0_readdata) : 64'(m1_readdata),
              64'(rd_model[other]));
        check("active_cycles", 64'(active_n), 64'(exp_active));
        check("latency_steps", 64'(steps), 64'(exp_active + 1));
        check("slave_fields_stable", 64'(fields_ok), 64'd1);
        rd_model[exp_m] = exp_rd;
        $display("txn master=%0d delay=%0d resp=%0d rd=%h active=%0d",
                 exp_m, delay, exp_resp, exp_rd, active_n);

        step();  // DONE -> IDLE: pulse must be over
        check("pulse_single", {61'd0, m0_ready, m1_ready, Hrequest}, 64'd0);
    endtask

    int exp_order [7] = '{0, 0, 0, 0, 1, 0, 0};

    initial begin
        rd_model[0] = '0; rd_model[1] = '0;
        for (int m = 0; m < 2; m++) new_fields(m, 1'b0);

        // reset state
        step(); step();
        check("rst_hrequest", 64'(Hrequest), 64'd0);
        check("rst_ready", {62'd0, m0_ready, m1_ready}, 64'd0);
        check("rst_readdata", {m0_readdata, m1_readdata}, 64'd0);
        check("rst_response", {62'd0, m0_response, m1_response}, 64'd0);
        check("rst_slave_out", {Haddress, Hwritedata}, 64'd0);
        reset = 1'b0;
        step();
        check("idle_no_req", 64'(Hrequest), 64'd0);

        // single read, slave ready in first ACTIVE cycle
        new_fields(0, 1'b0);
        m0_req = 1'b1;
        serve(1, 1'b0, 32'hDEADBEEF);
        m0_req = 1'b0;

        // simultaneous requests, 2-cycle slave
        new_fields(0, 1'b0); new_fields(1, 1'b1);
        m0_req = 1'b1; m1_req = 1'b1;
        serve(2, 1'b0, $urandom);
        check("both_first_m0", 64'(obs_winner), 64'd0);
        m0_req = 1'b0;
        serve(2, 1'b0, $urandom);
        check("both_second_m1", 64'(obs_winner), 64'd1);

        // anti-starvation: both held high continuously
        new_fields(0, 1'b0); new_fields(1, 1'b0);
        m0_req = 1'b1; m1_req = 1'b1;
        for (int i = 0; i < 7; i++) begin
            serve(1, 1'b0, $urandom);
            check($sformatf("streak_order_%0d", i), 64'(obs_winner), 64'(exp_order[i]));
            new_fields(obs_winner ? 1 : 0, 1'($urandom_range(0, 1)));
        end
        m1_req = 1'b0;

        // slave never answers -> timeout
        new_fields(0, 1'b0);
        serve(100, 1'b0, $urandom);
        // slave answers with error exactly when the timeout would fire
        new_fields(0, 1'b0);
        serve(TIMEOUT, 1'b1, 32'hA5A5_1234);
        new_fields(0, 1'b0);
        serve(TIMEOUT - 1, 1'b0, $urandom);
        m0_req = 1'b0;

        // random traffic
        for (int t = 0; t < 60; t++) begin
            int pick, dly;
            if (!m0_req && !m1_req) begin
                if ($urandom_range(0, 1) == 0) begin
                    new_fields(0, 1'($urandom_range(0, 1))); m0_req = 1'b1;
                end else begin
                    new_fields(1, 1'($urandom_range(0, 1))); m1_req = 1'b1;
                end
            end
            pick = $urandom_range(0, 9);
            dly  = (pick < 6) ? $urandom_range(1, 4) :
                   (pick == 6) ? TIMEOUT - 1 : (pick == 7) ? TIMEOUT :
                   (pick == 8) ? TIMEOUT + 1 : 40;
            serve(dly, 1'($urandom_range(0, 1)), $urandom);
            // winner may go again or drop; a waiting master keeps its request
            if (obs_winner == 1'b0) begin
                m0_req = 1'($urandom_range(0, 1));
                if (m0_req) new_fields(0, 1'($urandom_range(0, 1)));
                if (!m1_req && $urandom_range(0, 1) == 1) begin
                    new_fields(1, 1'($urandom_range(0, 1))); m1_req = 1'b1;
                end
            end else begin
                m1_req = 1'($urandom_range(0, 1));
                if (m1_req) new_fields(1, 1'($urandom_range(0, 1)));
                if (!m0_req && $urandom_range(0, 1) == 1) begin
                    new_fields(0, 1'($urandom_range(0, 1))); m0_req = 1'b1;
                end
            end
        end

        // reset in the middle of ACTIVE
        m0_req = 1'b0; m1_req = 1'b0;
        Hready = 1'b0;
        step(); step();
        new_fields(0, 1'b0);
        m0_req = 1'b1;
        step();
        check("pre_reset_active", 64'(Hrequest), 64'd1);
        new_fields(1, 1'b0);
        m1_req = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("async_rst_hrequest", 64'(Hrequest), 64'd0);
        check("async_rst_ready", {62'd0, m0_ready, m1_ready}, 64'd0);
        m0_req = 1'b0;
        streak_m = 0;
        rd_model[0] = '0; rd_model[1] = '0;
        step();
        check("rst_no_ready", {62'd0, m0_ready, m1_ready}, 64'd0);
        reset = 1'b0;
        serve(1, 1'b0, 32'h1357_9BDF);
        check("post_reset_m1", 64'(obs_winner), 64'd1);
        m1_req = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
